// File: rtl/mp_add_sub_pkg.sv
// Shared definitions for the multi-precision add/sub unit: FSM encoding and
// the bit positions of the flags inside the ALU status word.
package mp_add_sub_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int CF = 0;
    localparam int VF = 1;
    localparam int ZF = 2;
    localparam int FLAG_BITS = 3;

endpackage

// File: rtl/mp_add_sub_nbit_adder.sv
// Plain N-bit ripple adder with explicit carry in and carry out; one instance
// serves every chunk of the multi-precision operation.
module nbit_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
    assign sum   = total[N-1:0];
    assign cout  = total[N];

endmodule

// File: rtl/mp_add_sub.sv
// Sequential W-bit adder/subtractor: one N-bit chunk per clock, LSB chunk
// first, with a registered carry and carry/overflow/zero flags on completion.
module mp_add_sub
    import mp_add_sub_pkg::*;
#(
    parameter int N     = 8,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [N*WORDS-1:0] a,
    input  logic [N*WORDS-1:0] b,
    input  logic               addn_sub,
    output logic               busy,
    output logic               done,
    output logic [N*WORDS-1:0] s,
    output logic               cout,
    output logic               ovf,
    output logic               zero
);

    localparam int W  = N * WORDS;
    localparam int IW = $clog2(WORDS);
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    state_t               state;
    logic [W-1:0]         a_r;
    logic [W-1:0]         b_r;
    logic                 sub_r;
    logic                 carry;
    logic [IW-1:0]        idx;
    logic [W-1:0]         s_r;
    logic [FLAG_BITS-1:0] flags;

    logic [N-1:0] a_chunk;
    logic [N-1:0] b_chunk;
    logic [N-1:0] sum;
    logic         chunk_cout;
    logic [W-1:0] s_next;

    // Subtraction is A + ~B + 1: the inverted chunk here, the +1 via the carry seed.
    always_comb begin
        a_chunk = a_r[idx*N +: N];
        b_chunk = b_r[idx*N +: N] ^ {N{sub_r}};
        s_next  = s_r;
        s_next[idx*N +: N] = sum;
    end

    nbit_adder #(.N(N)) u_adder (
        .a    (a_chunk),
        .b    (b_chunk),
        .cin  (carry),
        .sum  (sum),
        .cout (chunk_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            sub_r <= 1'b0;
            carry <= 1'b0;
            idx   <= '0;
            s_r   <= '0;
            flags <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        sub_r <= addn_sub;
                        carry <= addn_sub;
                        idx   <= '0;
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    s_r   <= s_next;
                    carry <= chunk_cout;
                    idx   <= idx + IW'(1);
                    if (idx == LAST) begin
                        // Overflow: operands agree in sign but the result does not.
                        flags[CF] <= chunk_cout;
                        flags[VF] <= (a_r[W-1] == (b_r[W-1] ^ sub_r)) &&
                                     (sum[N-1] != a_r[W-1]);
                        flags[ZF] <= (s_next == '0);
                        idx       <= '0;
                        state     <= IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign s    = s_r;
    assign cout = flags[CF];
    assign ovf  = flags[VF];
    assign zero = flags[ZF];

endmodule

// File: tb/tb_mp_add_sub.sv
// Bench for mp_add_sub (N=8, WORDS=4): directed corner cases, handshake and
// reset scenarios, then random operations against a wide-arithmetic model.
module tb_mp_add_sub;

    localparam int N     = 8;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         addn_sub;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
    logic         zero;

    int n_checks;
    int n_fail;

    // expected result packed as {zero, ovf, cout, s}
    logic [W+2:0] exp_q[$];
    logic [W+2:0] last_res;

    mp_add_sub #(.N(N), .WORDS(WORDS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .addn_sub (addn_sub),
        .busy     (busy),
        .done     (done),
        .s        (s),
        .cout     (cout),
        .ovf      (ovf),
        .zero     (zero)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // reference model: whole-word arithmetic, signed range test for overflow
    function automatic logic [W+2:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                          input logic msub);
        logic [W:0] r;
        longint     sa;
        longint     lim;
        logic       v;
        lim = longint'(1) <<< (W - 1);
        if (msub) begin
            r  = {1'b0, ma} + {1'b0, ~mb} + (W+1)'(1);
            sa = longint'($signed(ma)) - longint'($signed(mb));
        end else begin
            r  = {1'b0, ma} + {1'b0, mb};
            sa = longint'($signed(ma)) + longint'($signed(mb));
        end
        v = (sa >= lim) || (sa < -lim);
        return {(r[W-1:0] == '0), v, r[W], r[W-1:0]};
    endfunction

    // driver: present a request between edges and record its expectation
    task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tsub);
        start    = 1'b1;
        a        = ta;
        b        = tb;
        addn_sub = tsub;
        exp_q.push_back(model(ta, tb, tsub));
    endtask

    task automatic check_result(input string tag);
        logic [W+2:0] e;
        e = exp_q.pop_front();
        last_res = e;
        check({tag, "_s"},    64'(s),    64'(e[W-1:0]));
        check({tag, "_cout"}, 64'(cout), 64'(e[W]));
        check({tag, "_ovf"},  64'(ovf),  64'(e[W+1]));
        check({tag, "_zero"}, 64'(zero), 64'(e[W+2]));
    endtask

    // full operation; returns #1 after the done edge (still in the done cycle)
    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tsub, input bit keep_start);
        launch(ta, tb, tsub);
        @(posedge clk); #1;
        if (keep_start) begin
            a = $urandom;
            b = $urandom;
        end else begin
            start = 1'b0;
        end
        check({tag, "_busy_acc"}, 64'(busy), 64'd1);
        for (int k = 1; k <= WORDS; k++) begin
            @(posedge clk); #1;
            if (keep_start) a = $urandom;
            if (k < WORDS) begin
                check({tag, "_busy_run"}, 64'(busy), 64'd1);
                check({tag, "_done_early"}, 64'(done), 64'd0);
            end else begin
                check({tag, "_done"}, 64'(done), 64'd1);
                check({tag, "_busy_end"}, 64'(busy), 64'd0);
                check_result(tag);
            end
        end
    endtask

    task automatic idle_check(input string tag);
        @(posedge clk); #1;
        check({tag, "_done_drop"}, 64'(done), 64'd0);
        check({tag, "_idle"}, 64'(busy), 64'd0);
        check({tag, "_hold"}, 64'({zero, ovf, cout, s}), 64'(last_res));
    endtask

    logic [W-1:0] da [10] = '{32'h0000_00FF, 32'h0000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF,
                              32'h1234_5678, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF,
                              32'h00FF_FF00, 32'hFFFF_FFFF};
    logic [W-1:0] db [10] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001,
                              32'h1234_5678, 32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF,
                              32'h0001_0100, 32'h0000_0000};
    logic         ds [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    logic [W-1:0] corners [4] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        n_checks = 0;
        n_fail   = 0;
        last_res = '0;
        rst_n    = 1'b0;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        addn_sub = 1'b0;

        #1;
        check("rst_state", 64'({busy, done, zero, ovf, cout, s}), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // directed corner cases
        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("dir%0d", i), da[i], db[i], ds[i], 1'b0);
            idle_check($sformatf("dir%0d", i));
        end

        // start held through RUN with operands changing: only the first request counts
        run_op("hold", 32'h0102_0304, 32'h1111_1111, 1'b0, 1'b1);
        start = 1'b0;
        idle_check("hold");

        // back-to-back: request presented in the done cycle is taken with no bubble
        run_op("b2b0", 32'hDEAD_BEEF, 32'h0000_1111, 1'b1, 1'b0);
        run_op("b2b1", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        run_op("b2b2", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0);
        idle_check("b2b2");

        // reset two cycles into an operation
        launch(32'h1234_5678, 32'h0F0F_0F0F, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out", 64'({busy, done, zero, ovf, cout, s}), 64'd0);
        void'(exp_q.pop_front());
        last_res = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < WORDS + 2; k++) begin
            @(posedge clk); #1;
            check("midrst_nodone", 64'({busy, done}), 64'd0);
        end
        run_op("post_rst", 32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b0);
        idle_check("post_rst");

        // random operations, mixing corner operands in now and then
        for (int i = 0; i < 60; i++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) ra = corners[$urandom_range(0, 3)];
            if ($urandom_range(0, 3) == 0) rb = corners[$urandom_range(0, 3)];
            if ($urandom_range(0, 7) == 0) rb = ra;
            run_op("rnd", ra, rb, 1'($urandom_range(0, 1)), 1'b0);
            if ($urandom_range(0, 1) == 1) idle_check("rnd");
        end

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
